// File: rtl/dual_port_memory.sv
// Dual-port word memory: read-only fetch port A, read/write data port B.
// A clear engine fills every word with INIT_VAL after reset.
module dual_port_memory #(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 256,
  parameter int               AW       = $clog2(DEPTH),
  parameter bit               SYNC_RD  = 1'b0,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    a_addr,
  output logic [WIDTH-1:0] a_rd,
  input  logic             b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_wd,
  output logic [WIDTH-1:0] b_rd,
  output logic             ready
);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [AW-1:0]    r_cnt;
  logic             w_last;
  logic             w_ready;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_a_in;
  logic             w_b_in;
  logic [WIDTH-1:0] w_a_raw;
  logic [WIDTH-1:0] w_b_raw;

  logic [WIDTH-1:0] r_mem [DEPTH];

  assign w_last  = (r_cnt == LP_LAST);
  assign w_ready = (r_state == S_READY);
  assign ready   = w_ready;
  assign w_a_in  = ({1'b0, a_addr} < LP_DEPTH);
  assign w_b_in  = ({1'b0, b_addr} < LP_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_CLEAR && !w_last) begin
        r_cnt <= r_cnt + AW'(1);
      end
    end
  end

  // The clear engine owns the single write port until READY.
  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_waddr = b_addr;
    w_wdata = b_wd;
    unique case (r_state)
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = INIT_VAL;
        if (w_last) begin
          w_next = S_READY;
        end
      end
      S_READY: begin
        w_we = b_we && w_b_in;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign w_a_raw = w_a_in ? r_mem[a_addr] : '0;
  assign w_b_raw = w_b_in ? r_mem[b_addr] : '0;

  // Reads sample the array before the same-edge write lands: read-first.
  if (SYNC_RD) begin : g_sync
    logic [WIDTH-1:0] r_a_rd;
    logic [WIDTH-1:0] r_b_rd;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_a_rd <= '0;
        r_b_rd <= '0;
      end else begin
        r_a_rd <= w_a_raw;
        r_b_rd <= w_b_raw;
      end
    end

    assign a_rd = w_ready ? r_a_rd : '0;
    assign b_rd = w_ready ? r_b_rd : '0;
  end else begin : g_async
    assign a_rd = w_ready ? w_a_raw : '0;
    assign b_rd = w_ready ? w_b_raw : '0;
  end

endmodule
